alu_op_sequencer: RTL

Request/response front end directly upstream of the 4-operation ALU (ADD, SUB, OR, SLL). Accepts one operation at a time through a valid/ready handshake and drives the ALU's 2-bit control code and both operands from registers. It captures the ALU result and returns it through a second valid/ready handshake. MUL is an additional operation that the ALU does not provide. The sequencer performs it as an iterative shift-add loop that uses only the ALU's ADD and SLL.

---
 rtl/alu_op_sequencer_pkg.sv | 28 ++
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer and the ALU controller.
// Holds the request op codes, the ALU control codes and the sequencer state enum.
package alu_op_sequencer_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_SLL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MADD,
    S_MSHL,
    S_DONE
  } state_t;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > OP_MUL;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester and the ALU op sequencer.
// The sequencer connects through the slave modport, the requester through master.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front end for the 4-op ALU: one op in flight, single-pass ops in EXEC, and MUL
// as a shift-add loop alternating ALU ADD (MADD) and ALU SLL (MSHL).
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus,
  output logic [1:0]         alu_ctrl,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result
);

  state_t           state, state_d;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;      // operand A, doubles as multiplicand during MUL
  logic [WIDTH-1:0] b_r;      // operand B, doubles as remaining multiplier bits
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] rsp_data_r;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_data  = rsp_data_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // ALU drive is decoded from registered state only; IDLE and DONE leave it at zero.
  always_comb begin
    state_d  = state;
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) state_d = (bus.req_op == OP_MUL) ? S_MADD : S_EXEC;
      end
      S_EXEC: begin
        alu_ctrl = op_is_reserved(op_r) ? ALU_ADD : op_r[1:0];
        alu_a    = a_r;
        alu_b    = b_r;
        state_d  = S_DONE;
      end
      S_MADD: begin
        alu_a   = acc_r;
        alu_b   = b_r[0] ? a_r : '0;
        state_d = S_MSHL;
      end
      S_MSHL: begin
        alu_ctrl = ALU_SLL;
        alu_a    = a_r;
        alu_b    = WIDTH'(1);
        state_d  = (b_r == '0) ? S_DONE : S_MADD;
      end
      S_DONE: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      acc_r      <= '0;
      rsp_data_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_r  <= bus.req_op;
            a_r   <= bus.req_a;
            b_r   <= bus.req_b;
            acc_r <= '0;
          end
        end
        S_EXEC: rsp_data_r <= op_is_reserved(op_r) ? '0 : alu_result;
        S_MADD: begin
          acc_r <= alu_result;
          b_r   <= b_r >> 1;
        end
        // b_r was already shifted in MADD, so zero here means the last set bit is consumed.
        S_MSHL: begin
          a_r <= alu_result;
          if (b_r == '0) rsp_data_r <= acc_r;
        end
        default: ;
      endcase
    end
  end

endmodule
